// File: rtl/fixed_point_divider_pkg.sv
// Fixed-point constants and state encoding shared by the Q16.16 datapath blocks
// (multiplier, FFT butterflies, divider).
package fixed_point_divider_pkg;

  localparam int unsigned FXP_WIDTH = 32;
  localparam int unsigned FXP_FRAC  = 16;

  localparam logic [FXP_WIDTH-1:0] FXP_MAX = 32'h7FFF_FFFF;
  localparam logic [FXP_WIDTH-1:0] FXP_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDiv  = 2'd1,
    StFix  = 2'd2
  } div_state_e;

endpackage

// File: rtl/fixed_point_divider_saturate.sv
// Combinational magnitude + sign to saturated two's-complement conversion,
// reusable by any datapath block producing a wide unsigned magnitude.
module fxp_saturate #(
  parameter int unsigned MagW = 48,
  parameter int unsigned W    = 32
) (
  input  logic [MagW-1:0] i_mag,
  input  logic            i_neg,
  output logic [W-1:0]    o_val
);

  localparam logic [MagW-1:0] PosLim = {{(MagW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [MagW-1:0] NegLim = {{(MagW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]    SatPos = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]    SatNeg = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] w_low;

  assign w_low = i_mag[W-1:0];

  always_comb begin
    o_val = w_low;
    if (i_neg) begin
      // A magnitude of exactly 2^(W-1) negates to the most negative value.
      o_val = (i_mag > NegLim) ? SatNeg : (~w_low + {{(W-1){1'b0}}, 1'b1});
    end else begin
      o_val = (i_mag > PosLim) ? SatPos : w_low;
    end
  end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed Q16.16 divider (restoring radix-2, one quotient bit per cycle),
// clocked on the falling edge to match the FFT datapath.
module fixed_point_divider
  import fixed_point_divider_pkg::*;
#(
  parameter int unsigned WIDTH = FXP_WIDTH,
  parameter int unsigned FRAC  = FXP_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] C
);

  localparam int unsigned Iter = WIDTH + FRAC;
  localparam int unsigned CntW = $clog2(Iter);
  localparam logic [CntW-1:0] CntLast = CntW'(Iter - 1);

  div_state_e       r_state;
  logic             r_sign_q;
  logic             r_sign_a;
  logic             r_bz;
  logic [WIDTH-1:0] r_mag_b;
  logic [Iter-1:0]  r_dividend;
  logic [WIDTH:0]   r_rem;
  logic [Iter-1:0]  r_quot;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_c;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_sat;

  // Unsigned reinterpretation makes 0x80000000 map to 2^31 without overflow.
  assign w_mag_a = A[WIDTH-1] ? (~A + {{(WIDTH-1){1'b0}}, 1'b1}) : A;
  assign w_mag_b = B[WIDTH-1] ? (~B + {{(WIDTH-1){1'b0}}, 1'b1}) : B;

  // Remainder stays below |B| <= 2^31, so WIDTH+1 bits hold the shifted value.
  assign w_rem_sh  = {r_rem[WIDTH-1:0], r_dividend[Iter-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_mag_b});
  assign w_rem_sub = w_rem_sh - {1'b0, r_mag_b};

  fxp_saturate #(
    .MagW (Iter),
    .W    (WIDTH)
  ) u_sat (
    .i_mag (r_quot),
    .i_neg (r_sign_q),
    .o_val (w_sat)
  );

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_sign_q   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_bz       <= 1'b0;
      r_mag_b    <= '0;
      r_dividend <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_c        <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_sign_q   <= A[WIDTH-1] ^ B[WIDTH-1];
            r_sign_a   <= A[WIDTH-1];
            r_bz       <= (B == '0);
            r_mag_b    <= w_mag_b;
            r_dividend <= {w_mag_a, {FRAC{1'b0}}};
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= CntLast;
            r_busy     <= 1'b1;
            r_state    <= StDiv;
          end
        end
        StDiv: begin
          r_rem      <= w_ge ? w_rem_sub : w_rem_sh;
          r_quot     <= {r_quot[Iter-2:0], w_ge};
          r_dividend <= {r_dividend[Iter-2:0], 1'b0};
          r_cnt      <= r_cnt - {{(CntW-1){1'b0}}, 1'b1};
          if (r_cnt == '0) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          if (r_bz) begin
            r_c   <= r_sign_a ? FXP_MIN : FXP_MAX;
            r_dbz <= 1'b1;
          end else begin
            r_c   <= w_sat;
            r_dbz <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign C           = r_c;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed-vector bench for fixed_point_divider: latency, rounding, saturation,
// divide-by-zero, busy-time start and mid-operation reset.
module tb_fixed_point_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] C;

  int n_checks;
  int n_fail;

  fixed_point_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .C           (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Called at a posedge; the following negedge is the accept edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
  endtask

  // Waits for done; scrambles A/B after accept. inj>0 pulses start at that cycle.
  task automatic wait_done(input string tag, input logic [31:0] exp_c, input logic exp_dbz,
                           input int inj);
    int cnt;
    int busy_cnt;
    cnt      = 0;
    busy_cnt = 0;
    while (cnt < 100) begin
      @(posedge clk);
      cnt++;
      if (busy) busy_cnt++;
      if (cnt == 1) begin
        check({tag, "_done_low"}, {31'd0, done}, 32'd0);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
      end
      if (inj > 0 && cnt == inj) begin
        A     = 32'h0001_0000;
        B     = 32'h0001_0000;
        start = 1'b1;
      end
      if (inj > 0 && cnt == inj + 1) start = 1'b0;
      if (done) break;
    end
    check({tag, "_latency"}, cnt, 32'd50);
    check({tag, "_busy_cycles"}, busy_cnt, 32'd49);
    check({tag, "_c"}, C, exp_c);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
  endtask

  initial begin
    int dones;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    A        = '0;
    B        = '0;
    repeat (3) @(posedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    check("reset_c", C, 32'd0);
    rst = 1'b1;
    @(posedge clk);

    launch(32'h0001_8000, 32'h0000_8000);
    wait_done("p1p5_div_0p5", 32'h0003_0000, 1'b0, 0);
    // Issued in the done cycle: must be accepted back-to-back.
    launch(32'hFFFD_0000, 32'h0002_0000);
    wait_done("neg3_div_2", 32'hFFFE_8000, 1'b0, 0);
    launch(32'h0001_0000, 32'h0003_0000);
    wait_done("trunc_pos", 32'h0000_5555, 1'b0, 0);
    launch(32'hFFFF_0000, 32'h0003_0000);
    wait_done("trunc_neg", 32'hFFFF_AAAB, 1'b0, 0);
    launch(32'h7FFF_0000, 32'h0000_0100);
    wait_done("sat_pos", 32'h7FFF_FFFF, 1'b0, 0);
    launch(32'h8000_0000, 32'h0000_0100);
    wait_done("sat_neg", 32'h8000_0000, 1'b0, 0);
    launch(32'h8000_0000, 32'h0001_0000);
    wait_done("min_exact", 32'h8000_0000, 1'b0, 0);
    launch(32'hFFFF_0000, 32'hFFFE_0000);
    wait_done("neg_div_neg", 32'h0000_8000, 1'b0, 0);
    launch(32'hFFFF_0000, 32'h0000_0000);
    wait_done("dbz_neg", 32'h8000_0000, 1'b1, 0);
    launch(32'h0001_0000, 32'h0000_0000);
    wait_done("dbz_pos", 32'h7FFF_FFFF, 1'b1, 0);
    launch(32'h0002_0000, 32'h0001_0000);
    wait_done("after_dbz", 32'h0002_0000, 1'b0, 0);

    launch(32'h0001_8000, 32'h0000_8000);
    wait_done("ignored_start", 32'h0003_0000, 1'b0, 10);
    dones = 0;
    repeat (60) begin
      @(posedge clk);
      if (done) dones++;
    end
    check("ignored_start_no_2nd_done", dones, 32'd0);

    launch(32'h0001_8000, 32'h0000_8000);
    @(posedge clk);
    start = 1'b0;
    repeat (19) @(posedge clk);
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_c", C, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(posedge clk);
    rst = 1'b1;
    dones = 0;
    repeat (60) begin
      @(posedge clk);
      if (done || busy) dones++;
    end
    check("rst_no_done_after", dones, 32'd0);
    check("rst_c_held", C, 32'd0);

    launch(32'hFFFD_0000, 32'h0002_0000);
    wait_done("post_rst", 32'hFFFE_8000, 1'b0, 0);
    @(posedge clk);
    check("post_rst_done_drop", {31'd0, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
